// File: rtl/imm_extender_pipe.sv
// imm_extender_pipe: elastic immediate extender with tag sideband, flush and illegal-format counter
module imm_extender_pipe #(
   parameter int XLEN       = 32,
   parameter int PIPE_DEPTH = 2,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      instr,
   input  logic [2:0]       immsrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  immext,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal,
   output logic [7:0]       err_count
);
   logic [XLEN-1:0]       ext;
   logic [XLEN-1:0]       dat [PIPE_DEPTH];
   logic [TAG_W-1:0]      tag [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] vld, ill;
   logic [PIPE_DEPTH:0]   rdy;
   // instr[k] holds instruction bit k+7
   always_comb
      ext = immsrc == 3'd0 ? XLEN'($signed(instr[24:13]))
          : immsrc == 3'd1 ? XLEN'($signed({instr[24:18], instr[4:0]}))
          : immsrc == 3'd2 ? XLEN'($signed({instr[24], instr[0], instr[23:18], instr[4:1], 1'b0}))
          : immsrc == 3'd3 ? XLEN'($signed({instr[24], instr[12:5], instr[13], instr[23:14], 1'b0}))
          : immsrc == 3'd4 ? XLEN'($signed({instr[24:5], 12'b0}))
          : immsrc == 3'd5 ? XLEN'(instr[12:8])
          : immsrc == 3'd6 ? (XLEN == 32 ? XLEN'(instr[17:13]) : XLEN'(instr[18:13]))
          : '0;
   always_comb begin
      rdy[PIPE_DEPTH] = out_ready;
      for (int i = PIPE_DEPTH - 1; i >= 0; i--)
         rdy[i] = !vld[i] || rdy[i+1];
   end
   assign in_ready  = !flush && rdy[0];
   assign out_valid = vld[PIPE_DEPTH-1];
   assign immext    = dat[PIPE_DEPTH-1];
   assign out_tag   = tag[PIPE_DEPTH-1];
   assign illegal   = ill[PIPE_DEPTH-1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            dat[k] <= '0;
            tag[k] <= '0;
         end
         vld       <= '0;
         ill       <= '0;
         err_count <= '0;
      end else begin
         if (in_valid && in_ready) begin
            dat[0] <= ext;
            tag[0] <= in_tag;
            ill[0] <= &immsrc;
         end
         vld[0] <= !flush && (rdy[0] ? in_valid : vld[0]);
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (rdy[k] && vld[k-1]) begin
               dat[k] <= dat[k-1];
               tag[k] <= tag[k-1];
               ill[k] <= ill[k-1];
            end
            vld[k] <= !flush && (rdy[k] ? vld[k-1] : vld[k]);
         end
         if (in_valid && in_ready && &immsrc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
endmodule

// File: tb/tb_imm_extender_pipe.sv
// tb_imm_extender_pipe: directed checks of the immediate extender pipe at XLEN 32 and 64
module tb_imm_extender_pipe;
   logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic [24:0] instr = '0;
   logic [2:0]  immsrc = '0;
   logic [4:0]  in_tag = '0;
   logic        in_ready, out_valid, illegal, in_ready64, out_valid64, illegal64;
   logic [31:0] immext;
   logic [63:0] immext64;
   logic [4:0]  out_tag, out_tag64;
   logic [7:0]  err_count, err_count64;
   int checks = 0, errors = 0, stalls = 0;
   typedef struct {
      logic [4:0]  tag;
      logic [31:0] e32;
      logic [63:0] e64;
      logic        ill;
   } item_t;
   item_t q[$];
   item_t cur, exp_item;

   imm_extender_pipe dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .immext(immext), .out_tag(out_tag), .illegal(illegal), .err_count(err_count));
   imm_extender_pipe #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
      .immext(immext64), .out_tag(out_tag64), .illegal(illegal64), .err_count(err_count64));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // scoreboard: record accepted items, compare each delivered item in order
   always @(negedge clk) if (rst_n) begin
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            exp_item = q.pop_front();
            chk("immext32", immext, exp_item.e32);
            chk("immext64", immext64, exp_item.e64);
            chk("out_tag", out_tag, exp_item.tag);
            chk("tag64", out_tag64, exp_item.tag);
            chk("illegal", illegal, exp_item.ill);
            chk("illegal64", illegal64, exp_item.ill);
         end
      end
      if (in_valid && in_ready) q.push_back(cur);
   end

   task automatic set_in(input logic [2:0] s, input logic [24:0] i, input logic [4:0] t,
                         input logic [31:0] e32, input logic [63:0] e64, input logic il);
      immsrc = s; instr = i; in_tag = t; in_valid = 1;
      cur = '{tag: t, e32: e32, e64: e64, ill: il};
   endtask

   task automatic accept();
      int n = 0;
      #1;
      while (!in_ready && n < 50) begin
         stalls++; n++;
         @(posedge clk); #1;
      end
      chk("accept", in_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [2:0] s, input logic [24:0] i, input logic [4:0] t,
                        input logic [31:0] e32, input logic [63:0] e64, input logic il);
      set_in(s, i, t, e32, e64, il);
      accept();
   endtask

   task automatic idle();
      in_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 rst_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_immext", immext, 0);
      chk("rst_immext64", immext64, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_err", err_count, 0);
      #20 rst_n = 1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_in_ready64", in_ready64, 1);
      // back-to-back stream of every legal format
      stalls = 0;
      drive(3'd0, 25'b1111_1111_1100_0000_0000_0000_0, 5'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      chk("latency_first_edge", out_valid, 0);
      drive(3'd1, {7'h7F, 13'b0, 5'b11100}, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      chk("latency_second_edge", out_valid, 1);
      drive(3'd2, {7'h7F, 13'b0, 5'b11101}, 5'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      drive(3'd3, 25'h0002000, 5'd4, 32'h00000800, 64'h800, 0);
      drive(3'd4, 25'h0000020, 5'd5, 32'h00001000, 64'h1000, 0);
      drive(3'd5, 25'h1001F00, 5'd6, 32'h0000001F, 64'h1F, 0);
      drive(3'd6, 25'h007E000, 5'd7, 32'h0000001F, 64'h3F, 0);
      drive(3'd4, 25'h1000000, 5'd8, 32'h80000000, 64'hFFFFFFFF80000000, 0);
      drive(3'd0, 25'h0FFE000, 5'd9, 32'h000007FF, 64'h7FF, 0);
      chk("stream_no_stall", stalls, 0);
      idle();
      drain();
      // illegal format
      for (int i = 0; i < 3; i++) drive(3'd7, 25'h1FFFFFF, 5'(10 + i), 32'h0, 64'h0, 1);
      idle();
      drain();
      chk("err_count_3", err_count, 3);
      chk("err_count64_3", err_count64, 3);
      // backpressure
      out_ready = 0;
      drive(3'd4, 25'h0000020, 5'd20, 32'h00001000, 64'h1000, 0);
      drive(3'd5, 25'h0001F00, 5'd21, 32'h0000001F, 64'h1F, 0);
      set_in(3'd0, 25'h1FF8000, 5'd22, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_immext", immext, 32'h1000);
         chk("bp_tag", out_tag, 20);
         @(posedge clk); #1;
      end
      out_ready = 1;
      #1;
      chk("release_in_ready", in_ready, 1);
      accept();
      drive(3'd1, {7'h7F, 13'b0, 5'b11100}, 5'd23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      idle();
      drain();
      // flush with simultaneous input
      out_ready = 0;
      drive(3'd4, 25'h0000020, 5'd24, 32'h00001000, 64'h1000, 0);
      drive(3'd4, 25'h0000020, 5'd25, 32'h00001000, 64'h1000, 0);
      set_in(3'd7, 25'h0, 5'd26, 32'h0, 64'h0, 1);
      flush = 1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 0;
      in_valid = 0;
      chk("flush_out_valid", out_valid, 0);
      q.delete();
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("flush_no_output", out_valid, 0);
      end
      chk("flush_err_count", err_count, 3);
      // saturation
      for (int i = 0; i < 300; i++) drive(3'd7, 25'(i), 5'(i), 32'h0, 64'h0, 1);
      idle();
      drain();
      chk("err_sat", err_count, 255);
      chk("err_sat64", err_count64, 255);
      // async reset with a full pipe
      out_ready = 0;
      drive(3'd0, 25'h1FF8000, 5'd27, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      drive(3'd0, 25'h1FF8000, 5'd28, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
      in_valid = 0;
      chk("full_out_valid", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_immext", immext, 0);
      chk("async_err", err_count, 0);
      chk("async_err64", err_count64, 0);
      q.delete();
      #10 rst_n = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
